mem_copy_dma: RTL and testbench

MEM_COPY_DMA -- requirements
Module: mem_copy_dma

---
 rtl/mem_copy_dma.sv | 123 ++++++++++++
 tb/tb_mem_copy_dma.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_dma.sv
// mem_copy_dma: single-channel word-copy DMA engine.
// Each word takes two cycles: READ captures the source word, WRITE stores it.
// A running 32-bit sum of the copied words is kept only when the macro
// MEM_COPY_DMA_CHECKSUM_EN is defined. Otherwise checksum is tied to zero.
module mem_copy_dma #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [31:0]      checksum,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_wd,
  output logic             mem_we,
  input  logic [31:0]      mem_rd
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [31:0]      buf_q, buf_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             start_acc;

  // Next-state logic and memory-side outputs, decoded from the current state only.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    busy        = 1'b0;
    done        = 1'b0;
    mem_address = 32'h0;
    mem_wd      = 32'h0;
    mem_we      = 1'b0;
    start_acc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          src_d     = src;
          dst_d     = dst;
          cnt_d     = len;
          state_d   = (len != '0) ? READ : DONE;
        end
      end
      READ: begin
        busy        = 1'b1;
        mem_address = src_q;
        buf_d       = mem_rd;
        src_d       = src_q + 32'd4;
        state_d     = WRITE;
      end
      WRITE: begin
        busy        = 1'b1;
        mem_address = dst_q;
        mem_wd      = buf_q;
        mem_we      = 1'b1;
        dst_d       = dst_q + 32'd4;
        cnt_d       = cnt_q - LEN_W'(1);
        state_d     = (cnt_q == LEN_W'(1)) ? DONE : READ;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset returns everything to zero/IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= 32'h0;
      dst_q   <= 32'h0;
      buf_q   <= 32'h0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MEM_COPY_DMA_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  // The sum clears when a start is accepted and accumulates each stored word.
  always_comb begin
    csum_d = csum_q;
    if (start_acc) begin
      csum_d = 32'h0;
    end else if (state_q == WRITE) begin
      csum_d = csum_q + buf_q;
    end
  end

  // Checksum register. It holds its value after DONE until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= 32'h0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed testbench for mem_copy_dma with a byte-addressed big-endian memory model.
module tb_mem_copy_dma;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] src, dst;
  logic [15:0] len;
  logic        busy, done, mem_we;
  logic [31:0] checksum, mem_address, mem_wd, mem_rd;

  logic [7:0]  mem [0:4095];
  logic        ld_en;
  logic [11:0] ld_addr;
  logic [31:0] ld_data;
  logic [11:0] ma;
  int          wr_cnt = 0;
  int          n_vec = 0;
  int          n_bad = 0;

`ifdef MEM_COPY_DMA_CHECKSUM_EN
  // 0x11223344 + 0x55667788 + 0x99AABBCC = 0x1_00336698, truncated to 32 bits
  localparam logic [31:0] CS3 = 32'h0033_6698;
`else
  localparam logic [31:0] CS3 = 32'h0;
`endif

  always #5 clk = ~clk;

  mem_copy_dma #(.LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .checksum(checksum),
    .mem_address(mem_address), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  assign ma     = mem_address[11:0];
  assign mem_rd = {mem[ma], mem[ma + 12'd1], mem[ma + 12'd2], mem[ma + 12'd3]};

  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr]         <= ld_data[31:24];
      mem[ld_addr + 12'd1] <= ld_data[23:16];
      mem[ld_addr + 12'd2] <= ld_data[15:8];
      mem[ld_addr + 12'd3] <= ld_data[7:0];
    end else if (mem_we) begin
      mem[ma]         <= mem_wd[31:24];
      mem[ma + 12'd1] <= mem_wd[23:16];
      mem[ma + 12'd2] <= mem_wd[15:8];
      mem[ma + 12'd3] <= mem_wd[7:0];
      wr_cnt          <= wr_cnt + 1;
    end
  end

  function automatic logic [31:0] rdw(input logic [11:0] a);
    return {mem[a], mem[a + 12'd1], mem[a + 12'd2], mem[a + 12'd3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [11:0] a, input logic [31:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    tick();
    ld_en   = 1'b0;
  endtask

  // Returns in cycle 1 with the inputs scrambled, so that latching can be checked.
  task automatic go(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    src   = s;
    dst   = d;
    len   = l;
    start = 1'b1;
    tick();
    start = 1'b0;
    src   = 32'hBAD0_0000;
    dst   = 32'hBAD1_0000;
    len   = 16'd7;
  endtask

  logic [31:0] words [0:2];
  logic [31:0] e_addr, e_wd;
  logic        e_we, done_seen;
  int          w0;

  initial begin
    words[0] = 32'h1122_3344;
    words[1] = 32'h5566_7788;
    words[2] = 32'h99AA_BBCC;
    rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    tick();
    ld(12'h100, words[0]);
    ld(12'h104, words[1]);
    ld(12'h108, words[2]);
    ld(12'hFFC, 32'hDEAD_BEEF);
    ld(12'h000, 32'hCAFE_F00D);
    ld(12'h140, 32'hA1A2_A3A4);
    ld(12'h144, 32'hB1B2_B3B4);
    ld(12'h180, 32'hEEEE_EEEE);
    start = 1'b1;
    tick();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst we", 32'(mem_we), 32'd0);
    chk("rst addr", mem_address, 32'h0);
    chk("rst wd", mem_wd, 32'h0);
    chk("rst csum", checksum, 32'h0);
    start = 1'b0;
    rst   = 1'b0;
    tick();

    // three-word copy, cycle-by-cycle
    w0 = wr_cnt;
    go(32'h100, 32'h200, 16'd3);
    for (int c = 1; c <= 9; c++) begin
      e_we   = (c <= 6) && (c % 2 == 0);
      e_addr = (c > 6) ? 32'h0 :
               (c % 2 == 1) ? 32'h100 + 32'(2 * (c - 1)) : 32'h200 + 32'(2 * (c - 2));
      e_wd   = e_we ? words[c / 2 - 1] : 32'h0;
      chk($sformatf("cp c%0d busy", c), 32'(busy), 32'((c <= 6) ? 1 : 0));
      chk($sformatf("cp c%0d done", c), 32'(done), 32'((c == 7) ? 1 : 0));
      chk($sformatf("cp c%0d we", c), 32'(mem_we), 32'(e_we));
      chk($sformatf("cp c%0d addr", c), mem_address, e_addr);
      chk($sformatf("cp c%0d wd", c), mem_wd, e_wd);
      tick();
    end
    chk("cp writes", 32'(wr_cnt - w0), 32'd3);
    chk("cp w0", rdw(12'h200), words[0]);
    chk("cp w1", rdw(12'h204), words[1]);
    chk("cp w2", rdw(12'h208), words[2]);
    chk("cp csum", checksum, CS3);
    tick(); tick();
    chk("cp csum hold", checksum, CS3);

    // zero-length request
    w0 = wr_cnt;
    go(32'h100, 32'h900, 16'd0);
    chk("z done c1", 32'(done), 32'd1);
    chk("z busy c1", 32'(busy), 32'd0);
    chk("z we c1", 32'(mem_we), 32'd0);
    chk("z csum", checksum, 32'h0);
    tick();
    chk("z done c2", 32'(done), 32'd0);
    tick();
    chk("z writes", 32'(wr_cnt - w0), 32'd0);

    // start re-pulsed with a different source mid-copy
    w0 = wr_cnt;
    go(32'h140, 32'h300, 16'd2);
    tick();
    start = 1'b1; src = 32'h180; dst = 32'h380; len = 16'd5;
    chk("rp addr c2", mem_address, 32'h300);
    tick();
    chk("rp addr c3", mem_address, 32'h144);
    tick();
    chk("rp addr c4", mem_address, 32'h304);
    tick();
    chk("rp done c5", 32'(done), 32'd1);
    tick();
    start = 1'b0;
    chk("rp busy c6", 32'(busy), 32'd0);
    tick();
    chk("rp busy c7", 32'(busy), 32'd0);
    chk("rp writes", 32'(wr_cnt - w0), 32'd2);
    chk("rp w0", rdw(12'h300), 32'hA1A2_A3A4);
    chk("rp w1", rdw(12'h304), 32'hB1B2_B3B4);

    // reset in cycle 3 of a four-word copy
    w0 = wr_cnt;
    go(32'h100, 32'h500, 16'd4);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ab busy", 32'(busy), 32'd0);
    chk("ab done", 32'(done), 32'd0);
    chk("ab we", 32'(mem_we), 32'd0);
    chk("ab addr", mem_address, 32'h0);
    chk("ab wd", mem_wd, 32'h0);
    chk("ab csum", checksum, 32'h0);
    done_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      done_seen = done_seen | done;
      tick();
    end
    chk("ab no done", 32'(done_seen), 32'd0);
    chk("ab writes", 32'(wr_cnt - w0), 32'd1);
    chk("ab w0", rdw(12'h500), words[0]);
    w0 = wr_cnt;
    go(32'h104, 32'h600, 16'd1);
    tick();
    tick();
    chk("ab2 done c3", 32'(done), 32'd1);
    tick();
    chk("ab2 writes", 32'(wr_cnt - w0), 32'd1);
    chk("ab2 w0", rdw(12'h600), words[1]);

    // source pointer wraps past 0xFFFFFFFC
    go(32'hFFFF_FFFC, 32'h700, 16'd2);
    chk("wr addr c1", mem_address, 32'hFFFF_FFFC);
    tick();
    chk("wr addr c2", mem_address, 32'h700);
    tick();
    chk("wr addr c3", mem_address, 32'h0000_0000);
    tick();
    chk("wr addr c4", mem_address, 32'h704);
    tick();
    chk("wr done c5", 32'(done), 32'd1);
    tick();
    chk("wr w0", rdw(12'h700), 32'hDEAD_BEEF);
    chk("wr w1", rdw(12'h704), 32'hCAFE_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
